// File: rtl/img_capture_packer.sv
// -----------------------------------------------------------------------------
// img_capture_packer
//
// Frame-capture engine between the CCD pixel pipeline and the network data
// memory. A start request arms the engine. It then waits for the next rising
// edge of frame-valid and accepts NUM_PXLS valid pixels. These are packed
// PXLS_PER_WORD at a time into wide words, and each word is written to
// consecutive Dmem addresses starting at 0. A partial final word is zero-padded.
// If frame-valid drops before the last pixel, the engine discards the partial
// word, pulses oAbort and re-arms for the next frame.
//
// Optional feature macro: IMG_CAP_THRESH_EN
//   defined   : each accepted pixel is binarised, giving all-ones when
//               iDATA >= iThresh (unsigned) and zero otherwise
//   undefined : pixels are stored raw and iThresh is unused
//
// Ports
//   clk          sole clock; pixel inputs are synchronous to it
//   rst_n        asynchronous active-low reset
//   iCCD_enable  block enable; low forces IDLE on the next edge
//   iStart       capture request (level-sampled in IDLE/DONE)
//   iFVAL        frame valid
//   iDVAL        pixel valid
//   iDATA        pixel value
//   iThresh      binarisation threshold (only with IMG_CAP_THRESH_EN)
//   oDmem_wren   one-cycle write strobe per packed word
//   oDmem_addr   word address
//   oDmem_data   packed word; lane 0 in the LSBs; holds between writes
//   oCCD_Done    capture complete (level, rises with the final write)
//   oBusy        high while waiting for a frame or capturing
//   oAbort       one-cycle pulse on an early frame end
// -----------------------------------------------------------------------------
module img_capture_packer #(
    parameter int PXL_W         = 16,
    parameter int PXLS_PER_WORD = 16,
    parameter int NUM_PXLS      = 784,
    parameter int ADDR_W        = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              iCCD_enable,
    input  logic                              iStart,
    input  logic                              iFVAL,
    input  logic                              iDVAL,
    input  logic [PXL_W-1:0]                  iDATA,
    input  logic [PXL_W-1:0]                  iThresh,
    output logic                              oDmem_wren,
    output logic [ADDR_W-1:0]                 oDmem_addr,
    output logic [PXL_W*PXLS_PER_WORD-1:0]    oDmem_data,
    output logic                              oCCD_Done,
    output logic                              oBusy,
    output logic                              oAbort
);

    localparam int WORD_W = PXL_W * PXLS_PER_WORD;
    localparam int CNT_W  = $clog2(NUM_PXLS + 1);
    localparam int LANE_W = $clog2(PXLS_PER_WORD);

    localparam logic [CNT_W-1:0]  LAST_PXL  = CNT_W'(NUM_PXLS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PXLS_PER_WORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_fval_q;
    logic [CNT_W-1:0]    r_cnt;
    logic [LANE_W-1:0]   r_lane;
    logic [ADDR_W-1:0]   r_waddr;
    logic [WORD_W-1:0]   r_pack;

    logic                r_wren;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_data;
    logic                r_done;
    logic                r_busy;
    logic                r_abort;

    // ------------------------------------------------------------------
    // Next-state / next-value wires
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [LANE_W-1:0]   w_lane_nxt;
    logic [ADDR_W-1:0]   w_waddr_nxt;
    logic [WORD_W-1:0]   w_pack_nxt;
    logic                w_wren_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [WORD_W-1:0]   w_data_nxt;
    logic                w_done_nxt;
    logic                w_busy_nxt;
    logic                w_abort_nxt;
    logic                w_arm;

    logic                w_frame_start;
    logic [PXL_W-1:0]    w_pix;
    logic [WORD_W-1:0]   w_merged;

    assign w_frame_start = iFVAL & ~r_fval_q;

`ifdef IMG_CAP_THRESH_EN
    assign w_pix = (iDATA >= iThresh) ? '1 : '0;
`else
    assign w_pix = iDATA;
    logic w_unused_thresh;
    assign w_unused_thresh = ^iThresh;
`endif

    // Pack register with the current pixel dropped into its lane. The pack
    // register is cleared after every write, so lanes above the current one
    // are already zero when a short final word is flushed.
    always_comb begin
        w_merged = r_pack;
        for (int unsigned i = 0; i < PXLS_PER_WORD; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_merged[i*PXL_W +: PXL_W] = w_pix;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    // The original per-state output decode is folded in here as next values
    // of the output registers, so every output stays registered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lane_nxt  = r_lane;
        w_waddr_nxt = r_waddr;
        w_pack_nxt  = r_pack;
        w_wren_nxt  = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_done_nxt  = r_done;
        w_abort_nxt = 1'b0;
        w_arm       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_done_nxt = 1'b0;
                if (iCCD_enable && iStart) begin
                    w_state_nxt = ST_WAIT_FRAME;
                    w_arm       = 1'b1;
                end
            end

            ST_WAIT_FRAME: begin
                // A pixel in the frame_start cycle itself is not captured.
                if (w_frame_start) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (!iFVAL) begin
                    // Early frame end: drop the partial word and re-arm.
                    w_abort_nxt = 1'b1;
                    w_state_nxt = ST_WAIT_FRAME;
                    w_arm       = 1'b1;
                end else if (iDVAL) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if ((r_cnt == LAST_PXL) || (r_lane == LAST_LANE)) begin
                        w_wren_nxt  = 1'b1;
                        w_addr_nxt  = r_waddr;
                        w_data_nxt  = w_merged;
                        w_waddr_nxt = r_waddr + ADDR_W'(1);
                        w_pack_nxt  = '0;
                        w_lane_nxt  = '0;
                    end else begin
                        w_pack_nxt  = w_merged;
                        w_lane_nxt  = r_lane + LANE_W'(1);
                    end
                    if (r_cnt == LAST_PXL) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (iCCD_enable && iStart) begin
                    w_state_nxt = ST_WAIT_FRAME;
                    w_done_nxt  = 1'b0;
                    w_arm       = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every entry to WAIT_FRAME restarts count, lane and address at 0.
        if (w_arm) begin
            w_cnt_nxt   = '0;
            w_lane_nxt  = '0;
            w_waddr_nxt = '0;
            w_pack_nxt  = '0;
        end

        // Disable overrides everything, including a pending abort or write.
        if (!iCCD_enable) begin
            w_state_nxt = ST_IDLE;
            w_wren_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_abort_nxt = 1'b0;
        end

        w_busy_nxt = (w_state_nxt == ST_WAIT_FRAME) || (w_state_nxt == ST_CAPTURE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fval_q <= 1'b0;
            r_cnt    <= '0;
            r_lane   <= '0;
            r_waddr  <= '0;
            r_pack   <= '0;
            r_wren   <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_fval_q <= iFVAL;
            r_cnt    <= w_cnt_nxt;
            r_lane   <= w_lane_nxt;
            r_waddr  <= w_waddr_nxt;
            r_pack   <= w_pack_nxt;
            r_wren   <= w_wren_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_abort  <= w_abort_nxt;
        end
    end

    assign oDmem_wren = r_wren;
    assign oDmem_addr = r_addr;
    assign oDmem_data = r_data;
    assign oCCD_Done  = r_done;
    assign oBusy      = r_busy;
    assign oAbort     = r_abort;

endmodule

// File: tb/tb_img_capture_packer.sv
// -----------------------------------------------------------------------------
// Testbench for img_capture_packer.
// u_dut   : default parameters (784 pixels, 16 per word, 49 words)
// u_small : NUM_PXLS=20, PXLS_PER_WORD=8 (partial final word)
// -----------------------------------------------------------------------------
module tb_img_capture_packer;

    localparam int WORDS = 49;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic         en, start, fval, dval;
    logic [15:0]  din, thr;
    logic         wren, done, busy, abort;
    logic [6:0]   addr;
    logic [255:0] wdata;

    img_capture_packer #(
        .PXL_W(16), .PXLS_PER_WORD(16), .NUM_PXLS(784), .ADDR_W(7)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .iCCD_enable(en), .iStart(start),
        .iFVAL(fval), .iDVAL(dval), .iDATA(din), .iThresh(thr),
        .oDmem_wren(wren), .oDmem_addr(addr), .oDmem_data(wdata),
        .oCCD_Done(done), .oBusy(busy), .oAbort(abort)
    );

    // small instance with a partial last word
    logic         s_en, s_start, s_fval, s_dval;
    logic [15:0]  s_din;
    logic         s_wren, s_done, s_busy, s_abort;
    logic [1:0]   s_addr;
    logic [127:0] s_dout;

    img_capture_packer #(
        .PXL_W(16), .PXLS_PER_WORD(8), .NUM_PXLS(20), .ADDR_W(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .iCCD_enable(s_en), .iStart(s_start),
        .iFVAL(s_fval), .iDVAL(s_dval), .iDATA(s_din), .iThresh(thr),
        .oDmem_wren(s_wren), .oDmem_addr(s_addr), .oDmem_data(s_dout),
        .oCCD_Done(s_done), .oBusy(s_busy), .oAbort(s_abort)
    );

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int salt = 0;

    function automatic logic [15:0] pix(input int k);
        return 16'(k * 37 + salt);
    endfunction

    function automatic logic [15:0] stored(input logic [15:0] v);
`ifdef IMG_CAP_THRESH_EN
        return (v >= 16'h0800) ? 16'hFFFF : 16'h0000;
`else
        return v;
`endif
    endfunction

    function automatic logic [255:0] exp_word(input int w);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) begin
            if (w * 16 + j < 784) v[j*16 +: 16] = stored(pix(w * 16 + j));
        end
        return v;
    endfunction

    function automatic logic [15:0] spix(input int k);
        case (k)
            0:       return 16'h07FF;
            1:       return 16'h0800;
            2:       return 16'hFFFF;
            default: return 16'(16'h1000 + k);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Write / abort monitor for u_dut
    // ------------------------------------------------------------------
    int   cyc = 0;
    int   wr_count = 0;
    int   last_cyc = 0;
    int   exp_spacing = 16;
    int   abort_count = 0;
    int   abort_hi = 0;
    logic prev_abort = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wren) begin
                chk($sformatf("wr%0d_addr", wr_count), 256'(addr), 256'(wr_count));
                chk($sformatf("wr%0d_data", wr_count), wdata, exp_word(wr_count));
                chk($sformatf("wr%0d_done", wr_count), 256'(done), 256'(wr_count == WORDS - 1));
                if (wr_count == WORDS - 1)
                    chk("done_before_last_wr", 256'(prev_done), 256'(0));
                if (wr_count > 0)
                    chk($sformatf("wr%0d_spacing", wr_count), 256'(cyc - last_cyc), 256'(exp_spacing));
                last_cyc = cyc;
                wr_count++;
            end
            if (abort) begin
                abort_hi++;
                if (!prev_abort) abort_count++;
            end
            prev_abort = abort;
            prev_done  = done;
        end
    end

    // ------------------------------------------------------------------
    // Write monitor for u_small
    // ------------------------------------------------------------------
    int           s_wr_n = 0;
    logic [1:0]   s_wr_addr [8];
    logic [127:0] s_wr_data [8];
    logic         s_wr_done [8];

    always @(negedge clk) begin
        if (rst_n && s_wren) begin
            if (s_wr_n < 8) begin
                s_wr_addr[s_wr_n] = s_addr;
                s_wr_data[s_wr_n] = s_dout;
                s_wr_done[s_wr_n] = s_done;
            end
            s_wr_n++;
        end
    end

    // ------------------------------------------------------------------
    // Scenario table (mode: 0 full frame, 1 iFVAL drop, 2 enable drop)
    // ------------------------------------------------------------------
    typedef struct {
        int   npix;
        int   gap;
        int   mode;
        int   spacing;
        int   exp_writes;
        int   exp_aborts;
        logic exp_done;
        logic exp_busy;
        logic start_pulse;
        int   salt;
    } scn_t;

    scn_t tbl [5];

    task automatic run_scn(input int idx);
        scn_t s;
        s = tbl[idx];
        salt        = s.salt;
        exp_spacing = s.spacing;
        wr_count    = 0;
        abort_count = 0;
        abort_hi    = 0;

        start = 1'b1;
        tick;
        start = 1'b0;
        chk($sformatf("s%0d_busy_after_start", idx), 256'(busy), 256'(1));
        chk($sformatf("s%0d_done_after_start", idx), 256'(done), 256'(0));
        tick;
        tick;

        // frame_start cycle carries a junk pixel that must be ignored
        fval = 1'b1;
        dval = 1'b1;
        din  = 16'hDEAD;
        tick;

        for (int k = 0; k < s.npix; k++) begin
            dval  = 1'b1;
            din   = pix(k);
            start = s.start_pulse && (k % 50 == 25);
            tick;
            start = 1'b0;
            for (int g = 0; g < s.gap; g++) begin
                dval = 1'b0;
                din  = 16'hBEEF;
                tick;
            end
        end

        if (s.mode == 1) fval = 1'b0;
        if (s.mode == 2) en = 1'b0;
        dval = 1'b1;
        din  = 16'h5A5A;
        tick;
        if (s.mode == 2) begin
            chk($sformatf("s%0d_dis_busy", idx), 256'(busy), 256'(0));
            chk($sformatf("s%0d_dis_wren", idx), 256'(wren), 256'(0));
            chk($sformatf("s%0d_dis_done", idx), 256'(done), 256'(0));
            chk($sformatf("s%0d_dis_abort", idx), 256'(abort), 256'(0));
        end
        repeat (30) tick;

        chk($sformatf("s%0d_writes", idx), 256'(wr_count), 256'(s.exp_writes));
        chk($sformatf("s%0d_aborts", idx), 256'(abort_count), 256'(s.exp_aborts));
        chk($sformatf("s%0d_abort_cycles", idx), 256'(abort_hi), 256'(s.exp_aborts));
        chk($sformatf("s%0d_done", idx), 256'(done), 256'(s.exp_done));
        chk($sformatf("s%0d_busy", idx), 256'(busy), 256'(s.exp_busy));

        fval = 1'b0;
        dval = 1'b0;
        en   = 1'b1;
        tick;
        tick;
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [127:0] s_exp [3];

        //          npix gap mode spc wr ab done  busy  stpls salt
        tbl[0] = '{784, 0,  0,   16, 49, 0, 1'b1, 1'b0, 1'b0, 1};
        tbl[1] = '{784, 1,  0,   32, 49, 0, 1'b1, 1'b0, 1'b1, 32'h2345};
        tbl[2] = '{100, 0,  1,   16, 6,  1, 1'b0, 1'b1, 1'b0, 7};
        tbl[3] = '{784, 0,  0,   16, 49, 0, 1'b1, 1'b0, 1'b0, 32'h4000};
        tbl[4] = '{40,  0,  2,   16, 2,  0, 1'b0, 1'b0, 1'b0, 9};

        en = 1'b0; start = 1'b0; fval = 1'b0; dval = 1'b0; din = '0;
        s_en = 1'b0; s_start = 1'b0; s_fval = 1'b0; s_dval = 1'b0; s_din = '0;
        thr = 16'h0800;

        repeat (3) tick;
        chk("rst_wren",  256'(wren),  256'(0));
        chk("rst_addr",  256'(addr),  256'(0));
        chk("rst_data",  wdata,       256'(0));
        chk("rst_done",  256'(done),  256'(0));
        chk("rst_busy",  256'(busy),  256'(0));
        chk("rst_abort", 256'(abort), 256'(0));
        rst_n = 1'b1;
        en    = 1'b1;
        tick;
        tick;

        for (int i = 0; i < 5; i++) run_scn(i);

        // Partial final word on the small instance
        s_en = 1'b1;
        tick;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        tick;
        s_fval = 1'b1;
        s_dval = 1'b1;
        s_din  = 16'hDEAD;
        tick;
        for (int k = 0; k < 20; k++) begin
            s_din = spix(k);
            tick;
        end
        s_din = 16'h5555;
        repeat (10) tick;

        for (int w = 0; w < 2; w++) begin
            s_exp[w] = '0;
            for (int j = 0; j < 8; j++) s_exp[w][j*16 +: 16] = stored(spix(w * 8 + j));
        end
        s_exp[2] = {64'h0, stored(spix(19)), stored(spix(18)), stored(spix(17)), stored(spix(16))};

        chk("small_writes", 256'(s_wr_n), 256'(3));
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("small_wr%0d_addr", w), 256'(s_wr_addr[w]), 256'(w));
            chk($sformatf("small_wr%0d_data", w), 256'(s_wr_data[w]), 256'(s_exp[w]));
            chk($sformatf("small_wr%0d_done", w), 256'(s_wr_done[w]), 256'(w == 2));
        end
        chk("small_done",  256'(s_done),  256'(1));
        chk("small_busy",  256'(s_busy),  256'(0));
        chk("small_abort", 256'(s_abort), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
